// File: rtl/pool_serializer.sv
// pool_serializer: snapshots all pooled maps when pool_done rises, then streams them
// one saturated element per cycle over valid/ready with channel/row/column indices.
module pool_serializer #(
    parameter int N_CH   = 8,
    parameter int POOL_X = 12,
    parameter int POOL_Y = 12,
    parameter int DATA_W = 69,
    parameter int OUT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pool_done,
    input  logic [DATA_W-1:0]         pool_result [N_CH][POOL_X][POOL_Y],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(N_CH)-1:0]   out_ch,
    output logic [$clog2(POOL_X)-1:0] out_x,
    output logic [$clog2(POOL_Y)-1:0] out_y,
    output logic                      out_ch_last,
    output logic                      out_last,
    output logic                      ser_busy,
    output logic                      ser_done,
    output logic                      overrun
);
    localparam int CW = $clog2(N_CH);
    localparam int XW = $clog2(POOL_X);
    localparam int YW = $clog2(POOL_Y);
    localparam logic [CW-1:0] C_MAX = CW'(N_CH - 1);
    localparam logic [XW-1:0] X_MAX = XW'(POOL_X - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(POOL_Y - 1);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state;
    logic             pool_done_q;
    logic             start;
    logic             hs;
    logic [CW-1:0]    nch;
    logic [XW-1:0]    nx;
    logic [YW-1:0]    ny;
    // Stored already saturated: the stream only ever needs the clipped value.
    logic [OUT_W-1:0] buf_q [N_CH][POOL_X][POOL_Y];

    function automatic logic [OUT_W-1:0] sat(input logic [DATA_W-1:0] v);
        return (|v[DATA_W-1:OUT_W]) ? {OUT_W{1'b1}} : v[OUT_W-1:0];
    endfunction

    assign start     = pool_done & ~pool_done_q;
    assign out_valid = (state == S_STREAM);
    assign hs        = out_valid & out_ready;
    assign ser_busy  = (state == S_CAPTURE) || (state == S_STREAM);
    assign ser_done  = (state == S_DONE);

    // Index of the element presented after this edge: y fastest, then x, then ch.
    always_comb begin
        nch = out_ch;
        nx  = out_x;
        ny  = out_y;
        if (state == S_CAPTURE) begin
            nch = '0;
            nx  = '0;
            ny  = '0;
        end else if (hs) begin
            ny  = (out_y == Y_MAX) ? '0 : out_y + 1'b1;
            nx  = (out_y != Y_MAX) ? out_x : (out_x == X_MAX) ? '0 : out_x + 1'b1;
            nch = (out_y != Y_MAX || out_x != X_MAX) ? out_ch :
                  (out_ch == C_MAX) ? '0 : out_ch + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pool_done_q <= 1'b0;
            overrun     <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_ch_last <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            pool_done_q <= pool_done;
            overrun     <= overrun | (start & (state != S_IDLE));
            state       <= (state == S_IDLE)    ? (start ? S_CAPTURE : S_IDLE) :
                           (state == S_CAPTURE) ? S_STREAM :
                           (state == S_STREAM)  ? ((hs && out_last) ? S_DONE : S_STREAM) :
                           S_IDLE;
            if (ser_busy) begin
                out_ch      <= nch;
                out_x       <= nx;
                out_y       <= ny;
                out_data    <= buf_q[nch][nx][ny];
                out_ch_last <= (nx == X_MAX) && (ny == Y_MAX);
                out_last    <= (nch == C_MAX) && (nx == X_MAX) && (ny == Y_MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state == S_IDLE && start)
            for (int c = 0; c < N_CH; c++)
                for (int x = 0; x < POOL_X; x++)
                    for (int y = 0; y < POOL_Y; y++)
                        buf_q[c][x][y] <= sat(pool_result[c][x][y]);
    end
endmodule

// File: tb/tb_pool_serializer.sv
// tb_pool_serializer: directed vectors and frame scoreboard for pool_serializer.
module tb_pool_serializer;
    localparam int NC = 8, PX = 12, PY = 12, DW = 69, OW = 16, NB = NC * PX * PY;
    localparam int LIMIT = 20000;

    logic clk = 0, rst = 1, pool_done = 0, out_ready = 0;
    logic [DW-1:0] pr [NC][PX][PY];
    logic out_valid, out_ch_last, out_last, ser_busy, ser_done, overrun;
    logic [OW-1:0] out_data;
    logic [2:0] out_ch;
    logic [3:0] out_x, out_y;
    logic [OW-1:0] exp_d [NC][PX][PY];
    logic [OW-1:0] rcv [NC][PX][PY];
    int n_vec = 0, n_bad = 0;

    typedef struct {
        int c; int x; int y;
        logic [DW-1:0] val;
        logic [OW-1:0] exp;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    pool_serializer dut (
        .clk(clk), .rst(rst), .pool_done(pool_done), .pool_result(pr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_x(out_x), .out_y(out_y), .out_ch_last(out_ch_last),
        .out_last(out_last), .ser_busy(ser_busy), .ser_done(ser_done), .overrun(overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] exp_tuple(input int b);
        int c, x, y;
        c = b / (PX * PY);
        x = (b / PY) % PX;
        y = b % PY;
        return {exp_d[c][x][y], 3'(c), 4'(x), 4'(y),
                x == PX - 1 && y == PY - 1, c == NC - 1 && x == PX - 1 && y == PY - 1};
    endfunction

    task automatic fill(input bit ramp);
        for (int c = 0; c < NC; c++)
            for (int x = 0; x < PX; x++)
                for (int y = 0; y < PY; y++) begin
                    pr[c][x][y]    = ramp ? DW'(c * 144 + x * 12 + y) : '0;
                    exp_d[c][x][y] = ramp ? OW'(c * 144 + x * 12 + y) : '0;
                end
    endtask

    task automatic start_frame(input bit hold);
        pool_done = 0;
        @(posedge clk); #1;
        pool_done = 1;
        @(posedge clk); #1;
        chk("capture_cycle", {out_valid, ser_busy}, 2'b01);
        if (!hold) pool_done = 0;
        @(posedge clk); #1;
        chk("first_valid_latency", {out_valid, ser_busy}, 2'b11);
    endtask

    // Called at posedge+1 with the stream already valid.
    task automatic run_frame(input int duty, input int stop_beat, input int poke_beat,
                             input int tail, output int beats, output int dones);
        int cyc, idle;
        bit stalled, last_hs, poked;
        logic [28:0] held, cur;
        cyc = 0; idle = 0; stalled = 0; last_hs = 0; poked = 0; held = '0;
        beats = 0; dones = 0;
        while (cyc < LIMIT) begin
            cur = {out_data, out_ch, out_x, out_y, out_ch_last, out_last};
            if (beats == stop_beat) return;
            if (beats == poke_beat && !poked) begin
                poked = 1;
                for (int c = 0; c < NC; c++)
                    for (int x = 0; x < PX; x++)
                        for (int y = 0; y < PY; y++) pr[c][x][y] = '1;
                pool_done = 1;
            end
            if (stalled) chk($sformatf("hold_beat%0d", beats), {out_valid, cur}, {1'b1, held});
            if (last_hs) chk("done_after_last", {ser_done, out_valid}, 2'b10);
            if (out_valid && beats < NB) begin
                chk($sformatf("beat%0d", beats), cur, exp_tuple(beats));
                rcv[beats / (PX * PY)][(beats / PY) % PX][beats % PY] = out_data;
            end
            if (ser_done) dones++;
            if (dones > 0) begin
                if (idle >= tail) return;
                idle++;
            end
            out_ready = (duty >= 100) || ($urandom_range(99) < duty);
            stalled = out_valid && !out_ready;
            held = cur;
            last_hs = out_valid && out_ready && beats == NB - 1;
            if (out_valid && out_ready) beats++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("frame_within_budget", cyc < LIMIT, 1);
    endtask

    initial begin
        int beats, dones;
        fill(0);
        #2 rst = 0;
        #10;
        chk("reset_flags", {out_valid, ser_busy, ser_done, overrun, out_last, out_ch_last}, 0);
        chk("reset_data", {out_data, out_ch, out_x, out_y}, 0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;

        // Ramp frame, ready always high
        fill(1);
        start_frame(0);
        run_frame(100, -1, -1, 2, beats, dones);
        chk("t1_beats", beats, NB);
        chk("t1_dones", dones, 1);
        chk("t1_overrun", overrun, 0);

        // Saturation vectors
        tbl[0] = '{0, 0, 0, 69'd0, 16'd0};
        tbl[1] = '{0, 0, 1, 69'd65535, 16'hFFFF};
        tbl[2] = '{0, 0, 2, 69'd65536, 16'hFFFF};
        tbl[3] = '{0, 0, 3, {DW{1'b1}}, 16'hFFFF};
        tbl[4] = '{3, 5, 7, 69'h1_0000_0000, 16'hFFFF};
        tbl[5] = '{7, 11, 11, 69'd12345, 16'd12345};
        tbl[6] = '{2, 4, 6, 69'd65534, 16'd65534};
        tbl[7] = '{5, 0, 11, 69'h1_0000_0000_0000_0001, 16'hFFFF};
        fill(0);
        for (int i = 0; i < 8; i++) begin
            pr[tbl[i].c][tbl[i].x][tbl[i].y]    = tbl[i].val;
            exp_d[tbl[i].c][tbl[i].x][tbl[i].y] = tbl[i].exp;
        end
        start_frame(0);
        run_frame(100, -1, -1, 2, beats, dones);
        for (int i = 0; i < 8; i++)
            chk($sformatf("sat_vec%0d", i), rcv[tbl[i].c][tbl[i].x][tbl[i].y], tbl[i].exp);
        chk("t2_beats", beats, NB);

        // Random backpressure at 30%
        fill(1);
        start_frame(0);
        run_frame(30, -1, -1, 2, beats, dones);
        chk("t3_beats", beats, NB);
        chk("t3_dones", dones, 1);

        // Second pool_done rise mid-stream with new data
        fill(1);
        start_frame(0);
        run_frame(100, -1, 500, 2, beats, dones);
        chk("t4_beats", beats, NB);
        chk("t4_dones", dones, 1);
        chk("t4_overrun_sticky", overrun, 1);
        pool_done = 0;

        // Asynchronous reset mid-stream
        fill(1);
        start_frame(0);
        run_frame(100, 300, -1, 2, beats, dones);
        chk("t5_valid_before_rst", out_valid, 1);
        #2 rst = 0;
        #1;
        chk("t5_async_rst", {out_valid, ser_busy, ser_done, overrun}, 0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1;
        chk("t5_no_done", {ser_done, out_valid, ser_busy}, 0);
        start_frame(0);
        run_frame(100, -1, -1, 2, beats, dones);
        chk("t5_restart_beats", beats, NB);
        chk("t5_restart_dones", dones, 1);

        // pool_done held high: exactly one frame
        fill(1);
        start_frame(1);
        run_frame(100, -1, -1, 1840, beats, dones);
        chk("t6_beats", beats, NB);
        chk("t6_dones", dones, 1);
        chk("t6_no_overrun", overrun, 0);
        pool_done = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
